countdown60: RTL and testbench

COUNTDOWN60 -- requirements
Module: countdown60

---
 rtl/countdown60.sv | 107 ++++++++++
 tb/tb_countdown60.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/countdown60.sv
// Two-digit BCD countdown timer (59..00) with load validation, pause/resume
// and optional auto-reload from the last accepted preset.
module countdown60 #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       start,
   input  logic       pause,
   input  logic       tick,
   output logic [7:0] qout,
   output logic       busy,
   output logic       done,
   output logic       load_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state, state_next;
   logic [7:0] reload, reload_next;
   logic [7:0] qout_next;
   logic       done_next, err_next, busy_next;
   logic       load_ok;

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
      else                return {v[7:4] - 4'd1, 4'd9};
   endfunction

   assign load_ok = load && (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      qout_next   = qout;
      reload_next = reload;
      done_next   = 1'b0;
      err_next    = 1'b0;

      if (load_ok) begin
         qout_next   = load_val;
         reload_next = load_val;
         state_next  = IDLE;
      end else begin
         // A rejected load is flagged but the rest of the cycle proceeds.
         err_next = load;
         unique case (state)
            IDLE: begin
               if (start && qout != 8'h00) state_next = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_next = PAUSE;
               end else if (tick) begin
                  if (qout == 8'h00) begin
                     // Only reachable with auto-reload: restart from the preset.
                     qout_next = reload;
                     if (reload == 8'h00) state_next = DONE;
                  end else if (qout == 8'h01) begin
                     qout_next = 8'h00;
                     done_next = 1'b1;
                     if (!AUTO_RELOAD) state_next = DONE;
                  end else begin
                     qout_next = bcd_dec(qout);
                  end
               end
            end
            PAUSE: begin
               if (start && !pause) state_next = RUN;
            end
            DONE: ;
            default: state_next = IDLE;
         endcase
      end

      busy_next = (state_next == RUN) || (state_next == PAUSE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         qout     <= 8'h00;
         reload   <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_next;
         qout     <= qout_next;
         reload   <= reload_next;
         busy     <= busy_next;
         done     <= done_next;
         load_err <= err_next;
      end
   end

endmodule

// File: tb/tb_countdown60.sv
// Directed, table-driven bench for countdown60; one instance per AUTO_RELOAD
// setting, both driven by the same stimulus.
module tb_countdown60;

   logic       clk = 1'b0;
   logic       reset;
   logic       load, start, pause, tick;
   logic [7:0] load_val;
   logic [7:0] q0, q1;
   logic       busy0, busy1, done0, done1, err0, err1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   countdown60 #(.AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .tick(tick),
      .qout(q0), .busy(busy0), .done(done0), .load_err(err0)
   );

   countdown60 #(.AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .tick(tick),
      .qout(q1), .busy(busy1), .done(done1), .load_err(err1)
   );

   typedef struct {
      logic       ld;
      logic [7:0] lv;
      logic       st;
      logic       ps;
      logic       tk;
      logic [7:0] q;
      logic       b;
      logic       d;
      logic       e;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] lv, input logic st,
                        input logic ps, input logic tk);
      load = ld; load_val = lv; start = st; pause = ps; tick = tk;
      @(posedge clk);
      #1;
   endtask

   task automatic check_dut0(input string tag, input logic [7:0] q, input logic b,
                             input logic d, input logic e);
      check({tag, ".qout"}, q0, q);
      check({tag, ".busy"}, {7'd0, busy0}, {7'd0, b});
      check({tag, ".done"}, {7'd0, done0}, {7'd0, d});
      check({tag, ".load_err"}, {7'd0, err0}, {7'd0, e});
   endtask

   task automatic check_dut1(input string tag, input logic [7:0] q, input logic b,
                             input logic d);
      check({tag, ".qout"}, q1, q);
      check({tag, ".busy"}, {7'd0, busy1}, {7'd0, b});
      check({tag, ".done"}, {7'd0, done1}, {7'd0, d});
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0; tick = 1'b0;

      //                ld   lv     st   ps   tk   q      b    d    e
      vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h19, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h50, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h49, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h6A, 1'b0, 1'b0, 1'b0, 8'h49, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h49, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h48, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h15, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h15, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h15, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h15, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h15, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0});

      // Reset held across edges, with a load request pending that must be ignored.
      load = 1'b1; load_val = 8'h33; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_dut0("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      check_dut1("reset_ar", 8'h00, 1'b0, 1'b0);
      #3 reset = 1'b1;

      // First edge after release processes the load in row 0.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps, vecs[i].tk);
         check_dut0($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].d, vecs[i].e);
      end

      // Asynchronous reset mid-countdown, asserted and released between edges.
      drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_dut0("pre_rst", 8'h41, 1'b1, 1'b0, 1'b0);
      #3 reset = 1'b0;
      #1;
      check_dut0("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      check_dut1("async_rst_ar", 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         check_dut0($sformatf("post_rst%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check_dut0("post_rst_start", 8'h00, 1'b0, 1'b0, 1'b0);

      // Auto-reload: 02 -> 01, 00(done), 02, 01, 00(done), 02 with busy held.
      drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      check_dut1("ar_load", 8'h02, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check_dut1("ar_start", 8'h02, 1'b1, 1'b0);
      begin
         logic [7:0] exp_q[6];
         logic       exp_d[6];
         exp_q = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
         exp_d = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check_dut1($sformatf("ar_tick%0d", i), exp_q[i], 1'b1, exp_d[i]);
         end
      end
      // Non-auto instance saw the same stimulus and must have stopped in DONE.
      check_dut0("nar_after", 8'h00, 1'b0, 1'b0, 1'b0);

      // Pause at 00 in auto-reload mode: no tick consumed, then resume reloads.
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_dut1("ar_q01", 8'h01, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_dut1("ar_q00", 8'h00, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      check_dut1("ar_pause00", 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check_dut1("ar_resume", 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_dut1("ar_reload", 8'h02, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
